alu_pipe: RTL and testbench

Parametrised two-stage integer execution unit between the ALU reservation station and the common data bus (CDB). Accepts one operation per cycle under a valid/ready handshake, carries a ROB tag through, computes arithmetic, logic, shift, compare and branch-condition results at configurable data width, and holds the result until the CDB grants it. Supports flush on `clear` and global stall on `rdy_in`.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_core.sv | 59 +++++
 rtl/alu_pipe.sv | 105 ++++++++++
 tb/tb_alu_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and default widths for the integer execution pipe.
package alu_pkg;

    localparam int unsigned DefaultXlen     = 32;
    localparam int unsigned DefaultRobWidth = 4;

    localparam logic [4:0] OpAdd   = 5'b00000;
    localparam logic [4:0] OpSub   = 5'b00001;
    localparam logic [4:0] OpAnd   = 5'b00010;
    localparam logic [4:0] OpOr    = 5'b00011;
    localparam logic [4:0] OpXor   = 5'b00100;
    localparam logic [4:0] OpSll   = 5'b00101;
    localparam logic [4:0] OpSrl   = 5'b00110;
    localparam logic [4:0] OpSra   = 5'b00111;
    localparam logic [4:0] OpSlt   = 5'b01000;
    localparam logic [4:0] OpSltu  = 5'b01001;
    localparam logic [4:0] OpPassb = 5'b01010;
    localparam logic [4:0] OpBeq   = 5'b10000;
    localparam logic [4:0] OpBne   = 5'b10001;
    localparam logic [4:0] OpBlt   = 5'b10100;
    localparam logic [4:0] OpBge   = 5'b10101;
    localparam logic [4:0] OpBltu  = 5'b10110;
    localparam logic [4:0] OpBgeu  = 5'b10111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: {a, b, op} -> {result, taken}. Undefined opcodes yield zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = DefaultXlen
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      op,
    output logic [XLEN-1:0] result,
    output logic            taken
);

    localparam int unsigned ShW = $clog2(XLEN);

    logic [ShW-1:0] shamt;
    logic           eq;
    logic           lt_s;
    logic           lt_u;

    // Only the low log2(XLEN) bits of b select the shift distance.
    assign shamt = b[ShW-1:0];
    assign eq    = (a == b);
    assign lt_s  = ($signed(a) < $signed(b));
    assign lt_u  = (a < b);

    // Decode the operation; compares and branches return a single condition bit.
    always_comb begin
        result = '0;
        taken  = 1'b0;
        case (op)
            OpAdd:   result = a + b;
            OpSub:   result = a - b;
            OpAnd:   result = a & b;
            OpOr:    result = a | b;
            OpXor:   result = a ^ b;
            OpSll:   result = a << shamt;
            OpSrl:   result = a >> shamt;
            OpSra:   result = $unsigned($signed(a) >>> shamt);
            OpSlt:   result = {{(XLEN-1){1'b0}}, lt_s};
            OpSltu:  result = {{(XLEN-1){1'b0}}, lt_u};
            OpPassb: result = b;
            OpBeq:   taken  = eq;
            OpBne:   taken  = !eq;
            OpBlt:   taken  = lt_s;
            OpBge:   taken  = !lt_s;
            OpBltu:  taken  = lt_u;
            OpBgeu:  taken  = !lt_u;
            default: begin
                result = '0;
                taken  = 1'b0;
            end
        endcase
        if (op[4]) begin
            result = {{(XLEN-1){1'b0}}, taken};
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage execution pipe: S1 holds operands, S2 holds the result until the CDB grants it.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned XLEN      = DefaultXlen,
    parameter int unsigned ROB_WIDTH = DefaultRobWidth
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_a,
    input  logic [XLEN-1:0]      in_b,
    input  logic [4:0]           in_op,
    input  logic [ROB_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [ROB_WIDTH-1:0] out_tag,
    output logic                 out_taken
);

    logic                 s1_valid_q;
    logic [XLEN-1:0]      s1_a_q;
    logic [XLEN-1:0]      s1_b_q;
    logic [4:0]           s1_op_q;
    logic [ROB_WIDTH-1:0] s1_tag_q;

    logic                 s2_valid_q;
    logic [XLEN-1:0]      s2_result_q;
    logic                 s2_taken_q;
    logic [ROB_WIDTH-1:0] s2_tag_q;

    logic [XLEN-1:0]      core_result;
    logic                 core_taken;
    logic                 s2_load;
    logic                 accept;

    // S2 can take a new entry when empty or being drained this cycle; S1 follows it.
    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = rdy_in && (!s1_valid_q || s2_load);
    assign accept   = in_valid && in_ready;

    alu_core #(
        .XLEN (XLEN)
    ) u_alu_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .op     (s1_op_q),
        .result (core_result),
        .taken  (core_taken)
    );

    // S1: capture accepted operations; empty out when advancing with nothing new behind.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                s1_valid_q <= 1'b0;
            end else if (accept) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= in_a;
                s1_b_q     <= in_b;
                s1_op_q    <= in_op;
                s1_tag_q   <= in_tag;
            end else if (s2_load) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    // S2: latch the ALU result; data holds its last value while the stage is empty.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_taken_q  <= 1'b0;
            s2_tag_q    <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                s2_valid_q <= 1'b0;
            end else if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_q <= core_result;
                    s2_taken_q  <= core_taken;
                    s2_tag_q    <= s1_tag_q;
                end
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_taken  = s2_taken_q;
    assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at XLEN=32 and XLEN=64.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // XLEN=32 instance
    logic        rdy, clr, in_valid, in_ready, out_valid, out_ready, out_taken;
    logic [31:0] in_a, in_b, out_result;
    logic [4:0]  in_op;
    logic [3:0]  in_tag, out_tag;

    // XLEN=64 instance
    logic        w_rdy, w_clr, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_taken;
    logic [63:0] w_in_a, w_in_b, w_out_result;
    logic [4:0]  w_in_op;
    logic [3:0]  w_in_tag, w_out_tag;

    int errors = 0;
    int checks = 0;
    int idx;
    int got;

    alu_pipe #(.XLEN(32), .ROB_WIDTH(4)) dut32 (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_taken(out_taken)
    );

    alu_pipe #(.XLEN(64), .ROB_WIDTH(4)) dut64 (
        .clk_in(clk), .rst_in(rst), .rdy_in(w_rdy), .clear(w_clr),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
        .in_op(w_in_op), .in_tag(w_in_tag), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_result(w_out_result), .out_tag(w_out_tag),
        .out_taken(w_out_taken)
    );

    // Directed throughput vectors: op, a, b, expected result, expected taken.
    localparam int NV = 14;
    logic [4:0]  v_op  [NV] = '{OpSra, OpSlt, OpSltu, OpBge, OpXor, OpSrl, OpSll,
                                OpPassb, OpBeq, OpBne, OpBlt, OpBltu, OpBgeu, OpOr};
    logic [31:0] v_a   [NV] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                                32'hFF00_FF00, 32'h8000_0000, 32'h3, 32'h1234, 32'd7,
                                32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0F};
    logic [31:0] v_b   [NV] = '{32'd4, 32'd1, 32'd1, 32'd5, 32'h0FF0_0FF0, 32'h24, 32'd8,
                                32'hCAFE_BABE, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0, 32'hF0};
    logic [31:0] v_res [NV] = '{32'hF800_0000, 32'd1, 32'd0, 32'd1, 32'hF0F0_F0F0,
                                32'h0800_0000, 32'h300, 32'hCAFE_BABE, 32'd1, 32'd0,
                                32'd1, 32'd0, 32'd1, 32'hFF};
    logic        v_tkn [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Backpressure vectors
    logic [4:0]  bp_op  [4] = '{OpAdd, OpSub, OpAnd, OpOr};
    logic [31:0] bp_a   [4] = '{32'd10, 32'd5, 32'h0000_F0F0, 32'h0F};
    logic [31:0] bp_b   [4] = '{32'd20, 32'd7, 32'h0000_FF00, 32'hF0};
    logic [31:0] bp_exp [4] = '{32'd30, 32'hFFFF_FFFE, 32'h0000_F000, 32'hFF};

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    task automatic offer64(input logic v, input logic [4:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] tag);
        w_in_valid = v;
        w_in_op    = op;
        w_in_a     = a;
        w_in_b     = b;
        w_in_tag   = tag;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1; clr = 1'b0; out_ready = 1'b1;
        offer(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        w_rdy = 1'b1; w_clr = 1'b0; w_out_ready = 1'b1;
        offer64(1'b0, 5'd0, 64'd0, 64'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // Reset state
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_taken", 64'(out_taken), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_valid64", 64'(w_out_valid), 64'd0);

        // Single ADD with wraparound into the sign bit
        offer(1'b1, OpAdd, 32'h7FFF_FFFF, 32'd1, 4'd3);
        step();
        in_valid = 1'b0;
        #1;
        check("add_latency_early", 64'(out_valid), 64'd0);
        step();
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_result", 64'(out_result), 64'h8000_0000);
        check("add_tag", 64'(out_tag), 64'd3);
        check("add_taken", 64'(out_taken), 64'd0);
        step();
        check("add_drained", 64'(out_valid), 64'd0);

        // Back-to-back stream, one result per cycle
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) offer(1'b1, v_op[i], v_a[i], v_b[i], 4'(i + 1));
            else in_valid = 1'b0;
            step();
            if (i >= 1) begin
                check("tp_valid", 64'(out_valid), 64'd1);
                check("tp_result", 64'(out_result), 64'(v_res[i-1]));
                check("tp_taken", 64'(out_taken), 64'(v_tkn[i-1]));
                check("tp_tag", 64'(out_tag), 64'(i));
            end
        end
        in_valid = 1'b0;
        step();
        check("tp_drained", 64'(out_valid), 64'd0);

        // Backpressure: out_ready low for the first 5 cycles
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 5);
            if (idx < 4) offer(1'b1, bp_op[idx], bp_a[idx], bp_b[idx], 4'(idx + 8));
            else in_valid = 1'b0;
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_hold_valid", 64'(out_valid), 64'd1);
                check("bp_hold_result", 64'(out_result), 64'(bp_exp[0]));
            end
            if (out_valid && out_ready) begin
                if (got < 4) begin
                    check("bp_result", 64'(out_result), 64'(bp_exp[got]));
                    check("bp_tag", 64'(out_tag), 64'(got + 8));
                end
                got++;
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        check("bp_consumed", 64'(got), 64'd4);
        check("bp_accepted", 64'(idx), 64'd4);

        // Flush with both stages full and a new op offered
        in_valid  = 1'b0;
        out_ready = 1'b0;
        offer(1'b1, OpAdd, 32'd1, 32'd1, 4'd9);
        step();
        offer(1'b1, OpAdd, 32'd2, 32'd2, 4'd10);
        step();
        offer(1'b1, OpAdd, 32'd3, 32'd3, 4'd11);
        #1;
        check("clr_full_valid", 64'(out_valid), 64'd1);
        check("clr_full_in_ready", 64'(in_ready), 64'd0);
        clr = 1'b1;
        out_ready = 1'b1;
        step();
        clr = 1'b0;
        offer(1'b1, OpAdd, 32'd4, 32'd4, 4'd12);
        #1;
        check("clr_flushed", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        #1;
        check("clr_no_stale", 64'(out_valid), 64'd0);
        step();
        check("clr_next_valid", 64'(out_valid), 64'd1);
        check("clr_next_result", 64'(out_result), 64'd8);
        check("clr_next_tag", 64'(out_tag), 64'd12);
        step();
        check("clr_after", 64'(out_valid), 64'd0);

        // rdy_in low mid-stream, with clear pulsed while frozen
        out_ready = 1'b1;
        offer(1'b1, OpSub, 32'd100, 32'd1, 4'd1);
        step();
        offer(1'b1, OpXor, 32'hF, 32'h3, 4'd2);
        step();
        rdy = 1'b0;
        offer(1'b1, OpOr, 32'h100, 32'h1, 4'd3);
        for (int k = 0; k < 3; k++) begin
            clr = (k == 1);
            #1;
            check("rdy_in_ready", 64'(in_ready), 64'd0);
            check("rdy_valid", 64'(out_valid), 64'd1);
            check("rdy_result", 64'(out_result), 64'd99);
            check("rdy_tag", 64'(out_tag), 64'd1);
            step();
        end
        rdy = 1'b1;
        clr = 1'b0;
        #1;
        check("rdy_resume", 64'(out_result), 64'd99);
        step();
        in_valid = 1'b0;
        #1;
        check("rdy_m2_result", 64'(out_result), 64'hC);
        check("rdy_m2_tag", 64'(out_tag), 64'd2);
        step();
        check("rdy_m3_result", 64'(out_result), 64'h101);
        check("rdy_m3_tag", 64'(out_tag), 64'd3);
        step();
        check("rdy_drained", 64'(out_valid), 64'd0);

        // XLEN=64 instance
        offer64(1'b1, OpSll, 64'd1, 64'd63, 4'd5);
        step();
        offer64(1'b1, OpSll, 64'd1, 64'd64, 4'd6);
        step();
        check("w_sll63", w_out_result, 64'h8000_0000_0000_0000);
        check("w_sll63_tag", 64'(w_out_tag), 64'd5);
        offer64(1'b1, 5'b01111, 64'hDEAD_BEEF, 64'h1234, 4'd7);
        step();
        check("w_sll64", w_out_result, 64'd1);
        check("w_sll64_tag", 64'(w_out_tag), 64'd6);
        w_in_valid = 1'b0;
        step();
        check("w_undef_valid", 64'(w_out_valid), 64'd1);
        check("w_undef_result", w_out_result, 64'd0);
        check("w_undef_taken", 64'(w_out_taken), 64'd0);
        check("w_undef_tag", 64'(w_out_tag), 64'd7);
        step();
        check("w_drained", 64'(w_out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
